// File: rtl/dz_stage_sel.sv
// dz_stage_sel: picks the dot-matrix image for the egg-hatch game.
// Maps egg progress to an egg image, latches a random animal image at hatch,
// and, on game failure, switches the matrix to green and blinks it until restart.
module dz_stage_sel #(
   parameter int NUM_W     = 5,
   parameter int STAGES    = 16,
   parameter int IMG_STEP  = 2,
   parameter int ANIMAL_W  = 2,
   parameter int IDX_W     = 4,
   parameter int BLINK_CYC = 24
) (
   input  logic             clk,
   input  logic             dst,
   input  logic             upd,
   input  logic [NUM_W-1:0] dz_num,
   input  logic             fail,
   input  logic             restart,
   output logic [IDX_W-1:0] img_idx,
   output logic             use_green,
   output logic             blink_on,
   output logic             hatched,
   output logic             upd_ack
);

   localparam int EGG_IMGS = STAGES / IMG_STEP;
   localparam int CNT_W    = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

   // Constants pre-sized so the compare/divide/add below stay width-exact.
   localparam logic [NUM_W:0]   HATCH_AT    = (NUM_W+1)'(STAGES);
   localparam logic [NUM_W-1:0] STEP        = NUM_W'(IMG_STEP);
   localparam logic [IDX_W-1:0] ANIMAL_BASE = IDX_W'(EGG_IMGS);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(BLINK_CYC - 1);

   typedef enum logic [1:0] {IDLE, GROW, SHOW, FAIL} state_t;

   // Everything the display driver sees, kept together as one registered bundle.
   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic             green;
      logic             blink;
      logic             hatched;
   } view_t;

   // idx=0, green=0, blink=1 (visible), hatched=0
   localparam view_t VIEW_RST = view_t'({{IDX_W{1'b0}}, 3'b010});

   state_t              state, nxt_state;
   view_t               view, nxt_view;
   logic [CNT_W-1:0]    blink_cnt, nxt_cnt;
   logic                nxt_ack;
   logic [7:0]          lfsr;
   logic                lfsr_fb;
   logic [ANIMAL_W-1:0] rnd;
   logic                map_hatch;
   logic [IDX_W-1:0]    map_idx;

   // Taps 8,6,5,4 give a maximal-length sequence, so a non-zero seed never hits 0.
   assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign rnd     = lfsr[ANIMAL_W-1:0];

   // Progress-to-image mapping; anything at or beyond STAGES counts as hatch.
   assign map_hatch = ({1'b0, dz_num} >= HATCH_AT);
   assign map_idx   = map_hatch ? (ANIMAL_BASE + IDX_W'(rnd))
                                : IDX_W'(dz_num / STEP);

   // Free-running random source; restart deliberately leaves it alone.
   always_ff @(posedge clk or posedge dst) begin
      if (dst) lfsr <= 8'hA5;
      else     lfsr <= {lfsr[6:0], lfsr_fb};
   end

   // FSM state register.
   always_ff @(posedge clk or posedge dst) begin
      if (dst) state <= IDLE;
      else     state <= nxt_state;
   end

   // Next state and next output bundle; priority restart > fail > upd.
   always_comb begin
      nxt_state = state;
      nxt_view  = view;
      nxt_cnt   = blink_cnt;
      nxt_ack   = upd & ~restart;
      if (restart) begin
         nxt_state = IDLE;
         nxt_view  = VIEW_RST;
         nxt_cnt   = '0;
      end else if (state == FAIL) begin
         // Only restart leaves FAIL; upd and fail are don't-cares here.
         if (blink_cnt == CNT_LAST) begin
            nxt_cnt        = '0;
            nxt_view.blink = ~view.blink;
         end else begin
            nxt_cnt = blink_cnt + 1'b1;
         end
      end else if (fail) begin
         // A coincident upd is still acked but its mapping is dropped.
         nxt_state      = FAIL;
         nxt_view.green = 1'b1;
         nxt_view.blink = 1'b1;
         nxt_cnt        = '0;
      end else if (upd && state != SHOW) begin
         nxt_view.idx = map_idx;
         if (map_hatch) begin
            nxt_view.hatched = 1'b1;
            nxt_state        = SHOW;
         end else begin
            nxt_state = GROW;
         end
      end
   end

   // Registered outputs, blink counter and ack pulse.
   always_ff @(posedge clk or posedge dst) begin
      if (dst) begin
         view      <= VIEW_RST;
         blink_cnt <= '0;
         upd_ack   <= 1'b0;
      end else begin
         view      <= nxt_view;
         blink_cnt <= nxt_cnt;
         upd_ack   <= nxt_ack;
      end
   end

   assign img_idx   = view.idx;
   assign use_green = view.green;
   assign blink_on  = view.blink;
   assign hatched   = view.hatched;

   // The random source must never lock up at zero.
   a_lfsr_nz: assert property (@(posedge clk) disable iff (dst) lfsr != 8'h00);

   // A latched animal always points into the animal image range.
   a_hatch_rng: assert property (@(posedge clk) disable iff (dst)
                                 view.hatched |-> (view.idx >= ANIMAL_BASE));

endmodule
